// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_server scratch memory.
//   state_e    : controller state (CLEAR sweep, then READY)
//   WORD_W     : data word width
//   REQ_ADDR_W : width of the request address buses
//   addr_bits  : log2 of a power-of-two depth
//   addr_oob   : true when any address bit above the index field is set
package mem_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned REQ_ADDR_W = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Number of index bits needed to address depth words (depth 2..65536).
    function automatic int unsigned addr_bits(input int unsigned depth);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 17; i++) begin
            if ((32'd1 << i) < depth) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // Any set bit above the index field makes the access out of range.
    function automatic logic addr_oob(input logic [REQ_ADDR_W-1:0] addr,
                                      input int unsigned           abits);
        return (addr >> abits) != '0;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Read-return pipeline: delays the read valid/data pair by READ_LAT cycles and
// holds the last returned word on o_data until the next read completes.
// READ_LAT = 0 passes the read straight through and keeps a hold register.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_valid      : a read was accepted this cycle
//   i_data       : word read from the array this cycle
//   o_valid      : one-cycle pulse when o_data carries new data
//   o_data       : returned word, held between reads
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data
);

    if (READ_LAT == 0) begin : g_bypass
        logic [WORD_W-1:0] hold_q;

        // Remember the last word so o_data stays stable between reads.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                hold_q <= '0;
            end else if (i_valid) begin
                hold_q <= i_data;
            end
        end

        assign o_valid = i_valid;
        assign o_data  = i_valid ? i_data : hold_q;
    end else begin : g_pipe
        logic [READ_LAT-1:0] valid_q;
        logic [WORD_W-1:0]   data_q [READ_LAT];

        // Data stages only load behind a valid, so the last stage doubles as
        // the output hold register.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_q <= '0;
                for (int i = 0; i < READ_LAT; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= i_valid;
                if (i_valid) begin
                    data_q[0] <= i_data;
                end
                for (int i = 1; i < READ_LAT; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign o_valid = valid_q[READ_LAT-1];
        assign o_data  = data_q[READ_LAT-1];
    end

endmodule

// File: rtl/mem_server.sv
// Word-addressed 64-bit scratch memory for the compute stage.
// After reset the array is swept to zero (one word per cycle); requests are
// accepted only once o_ready is high. Out-of-range accesses are flagged.
//   i_clk, i_rst                  : clock, asynchronous active-high reset
//   i_read_en/i_read_addr         : read request
//   o_read_data/o_read_valid      : read return after READ_LAT cycles
//   i_write_en/_addr/_data        : write request
//   o_ready                       : clear sweep finished
//   o_err_oob                     : sticky out-of-range flag
//   o_read_count/o_write_count    : accepted request counters (wrapping)
module mem_server
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_read_en,
    input  logic [63:0]      i_read_addr,
    output logic [63:0]      o_read_data,
    output logic             o_read_valid,
    input  logic             i_write_en,
    input  logic [63:0]      i_write_addr,
    input  logic [63:0]      i_write_data,
    output logic             o_ready,
    output logic             o_err_oob,
    output logic [CNT_W-1:0] o_read_count,
    output logic [CNT_W-1:0] o_write_count
);

    localparam int unsigned AW = addr_bits(DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              rd_acc_c, wr_acc_c;
    logic              rd_oob_c, wr_oob_c;
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;
    logic [WORD_W-1:0] mem_wdata_c;
    logic [WORD_W-1:0] rd_word_c;

    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;
    logic              err_q;

    // State register: clear sweep restarts from word 0 on every reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: step the clear pointer, leave CLEAR after the last word.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign rd_oob_c = addr_oob(i_read_addr, AW);
    assign wr_oob_c = addr_oob(i_write_addr, AW);

    // Outputs: request acceptance and the single array write port.
    always_comb begin
        o_ready     = 1'b0;
        rd_acc_c    = 1'b0;
        wr_acc_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        case (state_q)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = ptr_q;
            end
            READY: begin
                o_ready  = 1'b1;
                rd_acc_c = i_read_en;
                wr_acc_c = i_write_en;
                if (i_write_en && !wr_oob_c) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = i_write_addr[AW-1:0];
                    mem_wdata_c = i_write_data;
                end
            end
            default: begin
                o_ready = 1'b0;
            end
        endcase
    end

    // Array read sees the pre-edge contents, so a same-cycle write is not visible.
    assign rd_word_c = rd_oob_c ? '0 : mem_q[i_read_addr[AW-1:0]];

    // Array storage: no reset, the clear sweep initialises it.
    always_ff @(posedge i_clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Access counters and sticky out-of-range flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (rd_acc_c) begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
            if (wr_acc_c) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
            if ((rd_acc_c && rd_oob_c) || (wr_acc_c && wr_oob_c)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_read_count  = rd_cnt_q;
    assign o_write_count = wr_cnt_q;
    assign o_err_oob     = err_q;

    mem_read_pipe #(
        .READ_LAT (READ_LAT)
    ) u_read_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (rd_acc_c),
        .i_data  (rd_word_c),
        .o_valid (o_read_valid),
        .o_data  (o_read_data)
    );

endmodule

// File: tb/tb_mem_server.sv
// Bench for mem_server: three instances (READ_LAT 0, 1, 3) share one request
// stream; expected read results are logged at issue and consumed per instance.
module tb_mem_server;

    localparam int unsigned DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [63:0]       rd_addr = '0;
    logic [63:0]       wr_addr = '0;
    logic [63:0]       wr_data = '0;

    logic [2:0][63:0]  rd_data;
    logic [2:0]        vld;
    logic [2:0]        rdy;
    logic [2:0]        err;
    logic [2:0][31:0]  rcnt;
    logic [2:0][31:0]  wcnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel_cyc = 0;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        log_q[$];
    int          hd [3];
    logic [63:0] mdl [DEPTH];
    logic [63:0] last_data = '0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic        exp_err = 1'b0;
    logic        bench_ready = 1'b0;

    mem_server #(.DEPTH(DEPTH), .READ_LAT(0), .CNT_W(32)) dut_l0 (
        .i_clk(clk), .i_rst(rst),
        .i_read_en(rd_en), .i_read_addr(rd_addr),
        .o_read_data(rd_data[0]), .o_read_valid(vld[0]),
        .i_write_en(wr_en), .i_write_addr(wr_addr), .i_write_data(wr_data),
        .o_ready(rdy[0]), .o_err_oob(err[0]),
        .o_read_count(rcnt[0]), .o_write_count(wcnt[0])
    );

    mem_server #(.DEPTH(DEPTH), .READ_LAT(1), .CNT_W(32)) dut_l1 (
        .i_clk(clk), .i_rst(rst),
        .i_read_en(rd_en), .i_read_addr(rd_addr),
        .o_read_data(rd_data[1]), .o_read_valid(vld[1]),
        .i_write_en(wr_en), .i_write_addr(wr_addr), .i_write_data(wr_data),
        .o_ready(rdy[1]), .o_err_oob(err[1]),
        .o_read_count(rcnt[1]), .o_write_count(wcnt[1])
    );

    mem_server #(.DEPTH(DEPTH), .READ_LAT(3), .CNT_W(32)) dut_l3 (
        .i_clk(clk), .i_rst(rst),
        .i_read_en(rd_en), .i_read_addr(rd_addr),
        .o_read_data(rd_data[2]), .o_read_valid(vld[2]),
        .i_write_en(wr_en), .i_write_addr(wr_addr), .i_write_data(wr_data),
        .o_ready(rdy[2]), .o_err_oob(err[2]),
        .o_read_count(rcnt[2]), .o_write_count(wcnt[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    // Per-instance scoreboard: compare returns against the issue log.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (hd[d] < log_q.size() && !vld[d] &&
                    (log_q[hd[d]].cyc + lat_of(d)) < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missed_valid dut%0d: no valid at cycle %0d, required at cycle %0d",
                             d, cyc, log_q[hd[d]].cyc + lat_of(d));
                    hd[d]++;
                end
                if (vld[d] === 1'b1) begin
                    total++;
                    if (hd[d] >= log_q.size()) begin
                        bad++;
                        $display("FAIL unexpected_valid dut%0d: valid at cycle %0d data=%h, required no valid",
                                 d, cyc, rd_data[d]);
                    end else begin
                        if (rd_data[d] !== log_q[hd[d]].data ||
                            cyc != log_q[hd[d]].cyc + lat_of(d)) begin
                            bad++;
                            $display("FAIL read_data dut%0d: got %h at cycle %0d, required %h at cycle %0d",
                                     d, rd_data[d], cyc, log_q[hd[d]].data, log_q[hd[d]].cyc + lat_of(d));
                        end
                        hd[d]++;
                    end
                end
            end
        end
    end

    // Drive one request cycle and update the reference model.
    task automatic do_cycle(input logic re, input logic [63:0] ra,
                            input logic we, input logic [63:0] wa,
                            input logic [63:0] wd);
        exp_t e;
        rd_en   = re;
        rd_addr = ra;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        if (bench_ready) begin
            if (re) begin
                e.cyc  = cyc;
                e.data = ((ra >> 8) != 64'd0) ? 64'd0 : mdl[ra[7:0]];
                log_q.push_back(e);
                last_data = e.data;
                exp_rd++;
                if ((ra >> 8) != 64'd0) exp_err = 1'b1;
            end
            if (we) begin
                exp_wr++;
                if ((wa >> 8) != 64'd0) exp_err = 1'b1;
                else mdl[wa[7:0]] = wd;
            end
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; asserts reset, checks reset values, releases it.
    task automatic apply_reset();
        rst   = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        bench_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;
        exp_rd  = 0;
        exp_wr  = 0;
        exp_err = 1'b0;
        last_data = 64'd0;
        for (int d = 0; d < 3; d++) hd[d] = log_q.size();
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rdy[d] !== 1'b0 || vld[d] !== 1'b0 || err[d] !== 1'b0 ||
                rcnt[d] !== 32'd0 || wcnt[d] !== 32'd0 || rd_data[d] !== 64'd0) begin
                bad++;
                $display("FAIL reset_values dut%0d: rdy=%b vld=%b err=%b rc=%0d wc=%0d data=%h, required all zero",
                         d, rdy[d], vld[d], err[d], rcnt[d], wcnt[d], rd_data[d]);
            end
        end
        idle(3);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    // o_ready must stay low for exactly DEPTH cycles after reset release.
    task automatic wait_ready();
        while (cyc - rel_cyc < int'(DEPTH)) begin
            total++;
            if (rdy !== 3'b000) begin
                bad++;
                $display("FAIL ready_early: rdy=%b at %0d cycles after release, required 000",
                         rdy, cyc - rel_cyc);
            end
            idle(1);
        end
        total++;
        if (rdy !== 3'b111) begin
            bad++;
            $display("FAIL ready_late: rdy=%b at %0d cycles after release, required 111",
                     rdy, cyc - rel_cyc);
        end
        bench_ready = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        wait_ready();
    endtask

    task automatic test_write_read();
        do_cycle(1'b0, 64'd0, 1'b1, 64'd5, 64'h1234);
        do_cycle(1'b1, 64'd5, 1'b0, 64'd0, 64'd0);
        idle(5);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rcnt[d] !== 32'd1 || wcnt[d] !== 32'd1) begin
                bad++;
                $display("FAIL write_read_counts dut%0d: rc=%0d wc=%0d, required 1 1", d, rcnt[d], wcnt[d]);
            end
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < DEPTH; a++) begin
            if (a != 5) do_cycle(1'b1, 64'(a), 1'b0, 64'd0, 64'd0);
        end
        idle(5);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rcnt[d] !== 32'(exp_rd) || err[d] !== 1'b0) begin
                bad++;
                $display("FAIL clear_reads dut%0d: rc=%0d err=%b, required %0d 0", d, rcnt[d], err[d], exp_rd);
            end
        end
    endtask

    task automatic test_collision();
        do_cycle(1'b0, 64'd0, 1'b1, 64'd7, 64'hAA);
        do_cycle(1'b1, 64'd7, 1'b1, 64'd7, 64'hBB);
        do_cycle(1'b1, 64'd7, 1'b0, 64'd0, 64'd0);
        do_cycle(1'b1, 64'd20, 1'b0, 64'd0, 64'd0);
        do_cycle(1'b0, 64'd0, 1'b1, 64'd20, 64'h5555);
        idle(5);
    endtask

    task automatic test_oob();
        do_cycle(1'b0, 64'd0, 1'b1, 64'd3, 64'h33);
        do_cycle(1'b1, 64'h100, 1'b0, 64'd0, 64'd0);
        idle(2);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (err[d] !== 1'b1) begin
                bad++;
                $display("FAIL oob_read_err dut%0d: err=%b, required 1", d, err[d]);
            end
        end
        do_cycle(1'b0, 64'd0, 1'b1, 64'h1_0000_0003, 64'hDEAD);
        do_cycle(1'b1, 64'd3, 1'b0, 64'd0, 64'd0);
        idle(5);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (err[d] !== 1'b1 || rcnt[d] !== 32'(exp_rd) || wcnt[d] !== 32'(exp_wr)) begin
                bad++;
                $display("FAIL oob_counts dut%0d: err=%b rc=%0d wc=%0d, required 1 %0d %0d",
                         d, err[d], rcnt[d], wcnt[d], exp_rd, exp_wr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ra, wa;
        for (int i = 0; i < 200; i++) begin
            ra = (($urandom % 8) == 0) ? ({32'($urandom), 32'($urandom)} | 64'h100)
                                       : 64'($urandom_range(0, 15));
            wa = (($urandom % 8) == 0) ? ({32'($urandom), 32'($urandom)} | 64'h100)
                                       : 64'($urandom_range(0, 15));
            do_cycle(($urandom % 4) != 0, ra, ($urandom % 2) != 0, wa,
                     {32'($urandom), 32'($urandom)});
        end
        do_cycle(1'b1, 64'd7, 1'b0, 64'd0, 64'd0);
        idle(6);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rd_data[d] !== last_data || rcnt[d] !== 32'(exp_rd) ||
                wcnt[d] !== 32'(exp_wr) || err[d] !== exp_err) begin
                bad++;
                $display("FAIL b2b_hold dut%0d: data=%h rc=%0d wc=%0d err=%b, required %h %0d %0d %b",
                         d, rd_data[d], rcnt[d], wcnt[d], err[d], last_data, exp_rd, exp_wr, exp_err);
            end
        end
    endtask

    task automatic test_lat3_reset();
        do_cycle(1'b0, 64'd0, 1'b1, 64'd1, 64'h101);
        do_cycle(1'b0, 64'd0, 1'b1, 64'd2, 64'h202);
        do_cycle(1'b0, 64'd0, 1'b1, 64'd3, 64'h303);
        do_cycle(1'b1, 64'd1, 1'b0, 64'd0, 64'd0);
        do_cycle(1'b1, 64'd2, 1'b0, 64'd0, 64'd0);
        do_cycle(1'b1, 64'd3, 1'b0, 64'd0, 64'd0);
        idle(5);
        do_cycle(1'b1, 64'd1, 1'b0, 64'd0, 64'd0);
        do_cycle(1'b1, 64'd2, 1'b0, 64'd0, 64'd0);
        apply_reset();
        wait_ready();
    endtask

    task automatic test_not_ready();
        apply_reset();
        do_cycle(1'b0, 64'd0, 1'b1, 64'd9, 64'hFF);
        idle(245);
        do_cycle(1'b1, 64'd9, 1'b1, 64'd9, 64'hFF);
        do_cycle(1'b1, 64'h200, 1'b1, 64'h300, 64'hFF);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rcnt[d] !== 32'd0 || wcnt[d] !== 32'd0 || err[d] !== 1'b0) begin
                bad++;
                $display("FAIL not_ready_ignored dut%0d: rc=%0d wc=%0d err=%b, required 0 0 0",
                         d, rcnt[d], wcnt[d], err[d]);
            end
        end
        wait_ready();
        do_cycle(1'b1, 64'd9, 1'b0, 64'd0, 64'd0);
        idle(5);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rcnt[d] !== 32'd1 || wcnt[d] !== 32'd0) begin
                bad++;
                $display("FAIL not_ready_counts dut%0d: rc=%0d wc=%0d, required 1 0", d, rcnt[d], wcnt[d]);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) hd[d] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_clear_reads();
        test_collision();
        test_oob();
        test_back_to_back();
        test_lat3_reset();
        test_not_ready();
        idle(6);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (hd[d] != log_q.size()) begin
                bad++;
                $display("FAIL pending_reads dut%0d: consumed %0d, required %0d", d, hd[d], log_q.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
